// File: rtl/tilt_detector.sv
// tilt_detector: moving-average tilt classifier with enter/exit hysteresis
// and a consecutive-candidate debounce on the reported direction.
module tilt_detector #(
    parameter int unsigned WIN_LOG2 = 2,
    parameter logic [15:0] TH_ENTER = 16'd200,
    parameter logic [15:0] TH_EXIT  = 16'd120,
    parameter int unsigned HOLD     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [15:0] abs_x,
    input  logic [15:0] abs_y,
    input  logic        neg_x,
    input  logic        neg_y,
    output logic [15:0] avg_x,
    output logic [15:0] avg_y,
    output logic [2:0]  dir,
    output logic        dir_changed,
    output logic        win_full,
    output logic        overrun
);

    localparam int unsigned N  = 1 << WIN_LOG2;
    localparam int unsigned SW = 17 + WIN_LOG2;
    localparam int unsigned CW = $clog2(HOLD + 1);

    localparam logic [2:0] D_CENTER = 3'd0;
    localparam logic [2:0] D_RIGHT  = 3'd1;
    localparam logic [2:0] D_LEFT   = 3'd2;
    localparam logic [2:0] D_UP     = 3'd3;
    localparam logic [2:0] D_DOWN   = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        CLASSIFY
    } state_e;

    state_e state_q, state_d;

    logic signed [16:0]   smp_x_q, smp_x_d;
    logic signed [16:0]   smp_y_q, smp_y_d;
    logic signed [16:0]   buf_x_q [N];
    logic signed [16:0]   buf_y_q [N];
    logic signed [SW-1:0] sum_x_q, sum_x_d, sum_x_nx;
    logic signed [SW-1:0] sum_y_q, sum_y_d, sum_y_nx;
    logic [WIN_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [WIN_LOG2:0]    fill_q, fill_d;
    logic                 win_full_q, win_full_d;
    logic [15:0]          avg_x_q, avg_x_d;
    logic [15:0]          avg_y_q, avg_y_d;
    logic [2:0]           dir_q, dir_d;
    logic [2:0]           prev_q, prev_d;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_nx;
    logic                 chg_q, chg_d;
    logic                 ovr_q, ovr_d;
    logic                 buf_we;

    logic signed [16:0]   vx, vy;
    logic [16:0]          mag_x, mag_y;
    logic                 hold_ok, x_wins;
    logic [2:0]           cand;

    function automatic logic signed [16:0] to_s17(
        input logic [15:0] mag,
        input logic        neg
    );
        logic [16:0] m;
        if (neg) begin
            m = (mag > 16'h8000) ? 17'h08000 : {1'b0, mag};
            to_s17 = -m;
        end else begin
            m = (mag > 16'h7FFF) ? 17'h07FFF : {1'b0, mag};
            to_s17 = m;
        end
    endfunction

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (sample_valid) state_d = UPDATE;
            UPDATE:   state_d = CLASSIFY;
            CLASSIFY: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign sum_x_nx = sum_x_q + SW'(smp_x_q) - SW'(buf_x_q[wr_ptr_q]);
    assign sum_y_nx = sum_y_q + SW'(smp_y_q) - SW'(buf_y_q[wr_ptr_q]);

    // 17-bit magnitudes so that |-32768| compares as 32768
    always_comb begin
        vx    = {avg_x_q[15], avg_x_q};
        vy    = {avg_y_q[15], avg_y_q};
        mag_x = avg_x_q[15] ? -vx : vx;
        mag_y = avg_y_q[15] ? -vy : vy;
        unique case (1'b1)
            dir_q == D_RIGHT: hold_ok = !avg_x_q[15] && mag_x >= {1'b0, TH_EXIT};
            dir_q == D_LEFT:  hold_ok =  avg_x_q[15] && mag_x >= {1'b0, TH_EXIT};
            dir_q == D_UP:    hold_ok = !avg_y_q[15] && mag_y >= {1'b0, TH_EXIT};
            dir_q == D_DOWN:  hold_ok =  avg_y_q[15] && mag_y >= {1'b0, TH_EXIT};
            default:          hold_ok = 1'b0;
        endcase
        x_wins = mag_x >= mag_y;
        cand   = D_CENTER;
        if (hold_ok)
            cand = dir_q;
        else if (x_wins && mag_x >= {1'b0, TH_ENTER})
            cand = avg_x_q[15] ? D_LEFT : D_RIGHT;
        else if (!x_wins && mag_y >= {1'b0, TH_ENTER})
            cand = avg_y_q[15] ? D_DOWN : D_UP;
        cnt_nx = (cand == prev_q) ? cnt_q + 1'b1 : CW'(1);
    end

    always_comb begin
        smp_x_d    = smp_x_q;
        smp_y_d    = smp_y_q;
        sum_x_d    = sum_x_q;
        sum_y_d    = sum_y_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        win_full_d = win_full_q;
        avg_x_d    = avg_x_q;
        avg_y_d    = avg_y_q;
        dir_d      = dir_q;
        prev_d     = prev_q;
        cnt_d      = cnt_q;
        chg_d      = 1'b0;
        buf_we     = 1'b0;
        ovr_d      = ovr_q | (sample_valid & (state_q != IDLE));
        unique case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    smp_x_d = to_s17(abs_x, neg_x);
                    smp_y_d = to_s17(abs_y, neg_y);
                end
            end
            UPDATE: begin
                buf_we   = 1'b1;
                sum_x_d  = sum_x_nx;
                sum_y_d  = sum_y_nx;
                wr_ptr_d = wr_ptr_q + 1'b1;
                // low 16 bits of sum >>> WIN_LOG2
                avg_x_d  = sum_x_nx[WIN_LOG2 +: 16];
                avg_y_d  = sum_y_nx[WIN_LOG2 +: 16];
                if (!win_full_q) begin
                    fill_d = fill_q + 1'b1;
                    if (fill_q == (WIN_LOG2 + 1)'(N - 1)) win_full_d = 1'b1;
                end
            end
            CLASSIFY: begin
                if (win_full_q) begin
                    prev_d = cand;
                    if (cand == dir_q) begin
                        cnt_d = '0;
                    end else if (cnt_nx >= CW'(HOLD)) begin
                        dir_d = cand;
                        chg_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_nx;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smp_x_q    <= '0;
            smp_y_q    <= '0;
            sum_x_q    <= '0;
            sum_y_q    <= '0;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            win_full_q <= 1'b0;
            avg_x_q    <= '0;
            avg_y_q    <= '0;
            dir_q      <= D_CENTER;
            prev_q     <= D_CENTER;
            cnt_q      <= '0;
            chg_q      <= 1'b0;
            ovr_q      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                buf_x_q[i] <= '0;
                buf_y_q[i] <= '0;
            end
        end else begin
            smp_x_q    <= smp_x_d;
            smp_y_q    <= smp_y_d;
            sum_x_q    <= sum_x_d;
            sum_y_q    <= sum_y_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            win_full_q <= win_full_d;
            avg_x_q    <= avg_x_d;
            avg_y_q    <= avg_y_d;
            dir_q      <= dir_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            chg_q      <= chg_d;
            ovr_q      <= ovr_d;
            if (buf_we) begin
                buf_x_q[wr_ptr_q] <= smp_x_q;
                buf_y_q[wr_ptr_q] <= smp_y_q;
            end
        end
    end

    assign avg_x       = avg_x_q;
    assign avg_y       = avg_y_q;
    assign dir         = dir_q;
    assign dir_changed = chg_q;
    assign win_full    = win_full_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_tilt_detector.sv
// tb_tilt_detector: a reference model queues expected outputs per strobe;
// they are popped and compared as the DUT outputs settle.
module tb_tilt_detector;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [15:0] abs_x, abs_y;
    logic        neg_x, neg_y;
    logic [15:0] avg_x, avg_y;
    logic [2:0]  dir;
    logic        dir_changed, win_full, overrun;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [15:0] ax;
        logic [15:0] ay;
        logic [2:0]  dir;
        logic        chg;
        logic        full;
        logic        ovr;
    } exp_t;

    exp_t sb_q[$];

    int wx[N];
    int wy[N];
    int m_wp, m_fill, m_dir, m_prev, m_cnt;
    bit m_ovr;

    always #5 clk = ~clk;

    tilt_detector dut (
        .clk(clk),
        .rst(rst),
        .sample_valid(sample_valid),
        .abs_x(abs_x),
        .abs_y(abs_y),
        .neg_x(neg_x),
        .neg_y(neg_y),
        .avg_x(avg_x),
        .avg_y(avg_y),
        .dir(dir),
        .dir_changed(dir_changed),
        .win_full(win_full),
        .overrun(overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                      tag, got, got, exp, exp);
    endtask

    function automatic int to_int(input int mag, input bit neg);
        if (neg) return (mag > 32768) ? -32768 : -mag;
        return (mag > 32767) ? 32767 : mag;
    endfunction

    function automatic int fdiv(input int s);
        int q = s / N;
        if ((s % N) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            wx[i] = 0;
            wy[i] = 0;
        end
        m_wp = 0; m_fill = 0; m_dir = 0; m_prev = 0; m_cnt = 0;
        m_ovr = 1'b0;
        sb_q.delete();
    endtask

    task automatic model_push(input int xm, input bit xn,
                              input int ym, input bit yn);
        exp_t e;
        int sx, sy, qx, qy, ax, ay, mx, my, cand;
        bit hold;
        wx[m_wp] = to_int(xm, xn);
        wy[m_wp] = to_int(ym, yn);
        m_wp = (m_wp + 1) % N;
        if (m_fill < N) m_fill++;
        sx = 0; sy = 0;
        for (int i = 0; i < N; i++) begin
            sx += wx[i];
            sy += wy[i];
        end
        qx = fdiv(sx);
        qy = fdiv(sy);
        e.ax = qx[15:0];
        e.ay = qy[15:0];
        e.chg = 1'b0;
        if (m_fill == N) begin
            ax = int'($signed(e.ax));
            ay = int'($signed(e.ay));
            mx = (ax < 0) ? -ax : ax;
            my = (ay < 0) ? -ay : ay;
            hold = (m_dir == 1 && ax >= 0 && mx >= 120) ||
                   (m_dir == 2 && ax <  0 && mx >= 120) ||
                   (m_dir == 3 && ay >= 0 && my >= 120) ||
                   (m_dir == 4 && ay <  0 && my >= 120);
            if (hold) cand = m_dir;
            else if (mx >= my && mx >= 200) cand = (ax < 0) ? 2 : 1;
            else if (my > mx && my >= 200) cand = (ay < 0) ? 4 : 3;
            else cand = 0;
            if (cand == m_dir) begin
                m_cnt = 0;
            end else begin
                m_cnt = (cand == m_prev) ? m_cnt + 1 : 1;
                if (m_cnt >= 3) begin
                    m_dir = cand;
                    m_cnt = 0;
                    e.chg = 1'b1;
                end
            end
            m_prev = cand;
        end
        e.dir  = m_dir[2:0];
        e.full = (m_fill == N);
        e.ovr  = m_ovr;
        sb_q.push_back(e);
    endtask

    task automatic drive(input int xm, input bit xn, input int ym, input bit yn);
        abs_x = xm[15:0]; neg_x = xn;
        abs_y = ym[15:0]; neg_y = yn;
        sample_valid = 1'b1;
    endtask

    task automatic expect_out(input bit late);
        exp_t e;
        if (!late) @(negedge clk);
        chk("sb_depth", 32'(sb_q.size()), 1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        chk("avg_x", avg_x, e.ax);
        chk("avg_y", avg_y, e.ay);
        chk("win_full", win_full, e.full);
        chk("overrun", overrun, e.ovr);
        @(negedge clk);
        chk("dir", dir, e.dir);
        chk("dir_changed", dir_changed, e.chg);
        @(negedge clk);
        chk("pulse_end", dir_changed, 0);
    endtask

    task automatic send(input int xm, input bit xn, input int ym, input bit yn);
        drive(xm, xn, ym, yn);
        model_push(xm, xn, ym, yn);
        @(negedge clk);
        sample_valid = 1'b0;
        expect_out(1'b0);
    endtask

    task automatic send_double(input int xm, input int xm2);
        drive(xm, 1'b0, 0, 1'b0);
        m_ovr = 1'b1;
        model_push(xm, 1'b0, 0, 1'b0);
        @(negedge clk);
        drive(xm2, 1'b0, 0, 1'b0);
        @(negedge clk);
        sample_valid = 1'b0;
        expect_out(1'b1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_avg_x"}, avg_x, 0);
        chk({tag, "_avg_y"}, avg_y, 0);
        chk({tag, "_dir"}, dir, 0);
        chk({tag, "_dir_changed"}, dir_changed, 0);
        chk({tag, "_win_full"}, win_full, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        sample_valid = 1'b0;
        abs_x = '0; abs_y = '0;
        neg_x = 1'b0; neg_y = 1'b0;
        @(negedge clk);
        reset_dut();
        check_reset("por");

        repeat (4) send(300, 0, 0, 0);
        chk("fill4_avg_x", avg_x, 300);
        chk("fill4_dir", dir, 0);
        chk("fill4_full", win_full, 1);
        repeat (2) send(300, 0, 0, 0);
        chk("right_dir", dir, 1);

        repeat (4) send(150, 0, 0, 0);
        chk("hyst_avg", avg_x, 150);
        chk("hyst_hold", dir, 1);
        repeat (6) send(100, 0, 0, 0);
        chk("hyst_release", dir, 0);

        repeat (6) send(250, 1, 250, 0);
        chk("tie_avg_x", avg_x, 16'hFF06);
        chk("tie_dir", dir, 2);
        repeat (4) send(16'h8000, 1, 0, 0);
        chk("min_avg_x", avg_x, 16'h8000);
        repeat (4) send(16'hFFFF, 0, 16'hFFFF, 1);
        chk("clamp_pos", avg_x, 16'h7FFF);
        chk("clamp_neg", avg_y, 16'h8000);

        reset_dut();
        check_reset("rst2");
        send_double(400, 4000);
        chk("ovr_sticky", overrun, 1);
        repeat (2) send(400, 0, 0, 0);
        chk("ovr_fill3", win_full, 0);
        send(400, 0, 0, 0);
        chk("ovr_fill4", win_full, 1);
        chk("ovr_avg", avg_x, 400);

        drive(1000, 0, 500, 1);
        @(negedge clk);
        sample_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset("mid");
        send(800, 0, 0, 0);
        chk("post_rst_avg", avg_x, 200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tilt_detector.md
TILT_DETECTOR -- requirements
Module: tilt_detector

Interface
REQ-001 Parameter WIN_LOG2, default 2, log2 of moving-average window depth (window N = 2^WIN_LOG2).
REQ-002 Parameter TH_ENTER, default 16'd200, magnitude needed to enter a tilt direction.
REQ-003 Parameter TH_EXIT, default 16'd120, magnitude below which a held direction is released; TH_EXIT <= TH_ENTER.
REQ-004 Parameter HOLD, default 3, consecutive identical candidate classifications required to change direction.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 sample_valid  input  1  one-cycle strobe, new accelerometer sample present.
REQ-008 abs_x, abs_y  input  16 each  axis magnitude from the accelerometer reader.
REQ-009 neg_x, neg_y  input  1 each  axis sign, 1 = negative.
REQ-010 avg_x, avg_y  output  16 each  signed two's-complement moving average.
REQ-011 dir  output  3  0 CENTER, 1 RIGHT (+x), 2 LEFT (-x), 3 UP (+y), 4 DOWN (-y).
REQ-012 dir_changed  output  1  one-cycle pulse when dir updates.
REQ-013 win_full  output  1  window holds N real samples.
REQ-014 overrun  output  1  sticky; a sample_valid arrived while not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, UPDATE, CLASSIFY: IDLE->UPDATE on sample_valid; UPDATE->CLASSIFY; CLASSIFY->IDLE, unconditionally.
REQ-016 On sample_valid in IDLE, the inputs SHALL be captured: magnitude clamped to 0x7FFF if neg=0 and to 0x8000 if neg=1, then converted to a 17-bit signed value s.
REQ-017 UPDATE SHALL write s into a per-axis N-entry circular buffer at wr_ptr, update running sum = sum + s - oldest, and advance wr_ptr modulo N (wrap from N-1 to 0).
REQ-018 The sum SHALL be 17+WIN_LOG2 bits signed; avg = sum >>> WIN_LOG2 (arithmetic, truncating toward -inf), taken as the low 16 bits, registered at end of UPDATE.
REQ-019 avg_x/avg_y SHALL be valid 2 cycles after sample_valid (cycle N strobe -> cycle N+2 outputs).
REQ-020 A fill counter SHALL count samples; win_full asserts when it reaches N and stays high until reset.
REQ-021 CLASSIFY SHALL run only when win_full; otherwise dir and the debounce counter remain unchanged.
REQ-022 Candidate: if dir != CENTER and dir's own axis has the matching sign with |avg| >= TH_EXIT, candidate = dir; else if max(|avg_x|,|avg_y|) >= TH_ENTER, candidate = direction of the larger-magnitude axis (tie -> x axis); else CENTER.
REQ-023 Debounce: if candidate == dir, clear cnt; if candidate equals the previous candidate, cnt++, otherwise cnt = 1; when cnt reaches HOLD, dir <= candidate, dir_changed pulses 1 cycle (cycle N+3 after the deciding strobe), cnt = 0.
REQ-024 sample_valid in UPDATE or CLASSIFY SHALL be dropped and SHALL set overrun; simultaneous sample_valid with the CLASSIFY->IDLE transition is dropped.
REQ-025 |avg| for -32768 SHALL evaluate as 32768 (17-bit compare).

Reset
REQ-026 While rst is high at a clk edge: FSM = IDLE; buffers, sums, wr_ptr, fill counter, cnt = 0; avg_x = avg_y = 0; dir = CENTER; dir_changed = 0; win_full = 0; overrun = 0.
REQ-027 rst asserted mid-operation SHALL abort the current sample with no partial buffer write visible after reset.

Verification
REQ-028 Reset, then 4 strobes of x=+300 (neg_x=0), y=0, spaced by 4 cycles -> avg_x = 75, 150, 225, 300; win_full rises after the 4th; dir stays CENTER (first classification, cnt = 1).
REQ-029 Continue x=+300 for 2 more strobes -> dir = 1 (RIGHT) with one dir_changed pulse, 3 cycles after the 6th strobe.
REQ-030 Hysteresis: from RIGHT at avg 300, feed x=+150 until avg = 150 -> dir stays RIGHT; feed x=+100 until avg = 100 for 3 classifications -> dir = CENTER.
REQ-031 Sign/tie: window full of x = -250, y = +250 -> dir = 2 (LEFT); abs=0x8000, neg=1 x4 -> avg_x = 0x8000.
REQ-032 Strobes on consecutive cycles -> 2nd strobe dropped, overrun = 1, fill count +1 only; a mid-UPDATE rst clears all outputs to their reset values.
